cdc_clear_phase_responder: RTL and testbench

Receiving-side agent of the CDC clear sequence: accepts clear-sequence phase requests (`cdc_reset_ctrlr_pkg::clear_seq_phase_e`) from the clear controller, already synchronized into the local clock domain. For each request it drives the local isolate and clear controls, waits for the local logic to confirm each step, then acknowledges. One instance sits on each side of every clearable CDC, between the phase synchronizer and the local FIFO/handshake logic.

---
 rtl/cdc_clear_phase_responder.sv | 145 ++++++++++++++
 tb/tb_cdc_clear_phase_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_clear_phase_responder.sv
// Receiving-side agent of the CDC clear sequence: applies synchronized clear-sequence phase
// requests to the local isolate/clear controls and acknowledges once the local logic confirms.

package cdc_reset_ctrlr_pkg;
  typedef enum logic [1:0] {
    PhaseIdle      = 2'd0,
    PhaseIsolate   = 2'd1,
    PhaseClear     = 2'd2,
    PhasePostClear = 2'd3
  } clear_seq_phase_e;
endpackage

module cdc_clear_phase_responder
  import cdc_reset_ctrlr_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  clear_seq_phase_e phase_i,
  input  logic             phase_valid_i,
  output logic             phase_ready_o,
  output logic             isolate_o,
  input  logic             isolate_ack_i,
  output logic             clear_o,
  output clear_seq_phase_e phase_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    StWait,
    StIsoSet,
    StClrHold,
    StIsoRel,
    StResp
  } state_e;

  localparam logic [7:0] CntLoad = 8'(CLEAR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             iso_q, iso_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;
  clear_seq_phase_e phase_q, phase_d;
  clear_seq_phase_e req_q, req_d;
  logic             upd_q, upd_d;

  logic to_isolate, to_clear, to_post_clear, to_idle;

  assign to_isolate    = (phase_q == PhaseIdle)      && (phase_i == PhaseIsolate);
  assign to_clear      = (phase_q == PhaseIsolate)   && (phase_i == PhaseClear);
  assign to_post_clear = (phase_q == PhaseClear)     && (phase_i == PhasePostClear);
  assign to_idle       = (phase_q == PhasePostClear) && (phase_i == PhaseIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iso_d   = iso_q;
    clr_d   = clr_q;
    err_d   = 1'b0;
    phase_d = phase_q;
    req_d   = req_q;
    upd_d   = upd_q;

    unique case (state_q)
      StWait: begin
        if (phase_valid_i) begin
          req_d = phase_i;
          upd_d = 1'b1;
          if (phase_i == phase_q) begin
            state_d = StResp;
          end else if (to_isolate) begin
            iso_d   = 1'b1;
            state_d = StIsoSet;
          end else if (to_clear) begin
            clr_d   = 1'b1;
            cnt_d   = CntLoad;
            state_d = StClrHold;
          end else if (to_post_clear) begin
            clr_d   = 1'b0;
            state_d = StResp;
          end else if (to_idle) begin
            iso_d   = 1'b0;
            state_d = StIsoRel;
          end else begin
            // Illegal transition: flag it and acknowledge without touching the controls.
            err_d   = 1'b1;
            upd_d   = 1'b0;
            state_d = StResp;
          end
        end
      end
      StIsoSet: begin
        if (isolate_ack_i) state_d = StResp;
      end
      StClrHold: begin
        if (cnt_q == 8'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StIsoRel: begin
        if (!isolate_ack_i) state_d = StResp;
      end
      StResp: begin
        // Completes even if valid was withdrawn early.
        state_d = StWait;
        if (upd_q) phase_d = req_q;
        upd_d = 1'b0;
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StWait;
      cnt_q   <= 8'd0;
      iso_q   <= 1'b0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= PhaseIdle;
      req_q   <= PhaseIdle;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iso_q   <= iso_d;
      clr_q   <= clr_d;
      err_q   <= err_d;
      phase_q <= phase_d;
      req_q   <= req_d;
      upd_q   <= upd_d;
    end
  end

  assign phase_ready_o = (state_q == StResp);
  assign isolate_o     = iso_q;
  assign clear_o       = clr_q;
  assign err_o         = err_q;
  assign phase_o       = phase_q;

endmodule

// File: tb/tb_cdc_clear_phase_responder.sv
// Self-checking bench for cdc_clear_phase_responder: directed scenarios on three instances
// (CLEAR_CYCLES = 3, 10, 1) plus a randomized request stream checked against a phase model.

module tb_cdc_clear_phase_responder;
  import cdc_reset_ctrlr_pkg::*;

  localparam int NU = 3;

  logic             clk = 1'b0;
  logic             rst_n  [NU];
  logic             valid  [NU];
  clear_seq_phase_e ph_in  [NU];
  logic             ready  [NU];
  logic             iso    [NU];
  logic             ack    [NU];
  logic             clr    [NU];
  logic             err    [NU];
  clear_seq_phase_e ph_out [NU];
  logic [7:0]       iso_hist [NU];

  logic       ack_manual;
  logic       ack_man;
  logic [2:0] ack_dly;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Local logic model: acknowledge follows isolate_o through a delay line.
  always @(posedge clk) begin
    for (int i = 0; i < NU; i++) begin
      if (!rst_n[i]) iso_hist[i] <= 8'd0;
      else           iso_hist[i] <= {iso_hist[i][6:0], iso[i]};
    end
  end

  assign ack[0] = ack_manual ? ack_man : iso_hist[0][ack_dly - 3'd1];
  assign ack[1] = iso_hist[1][0];
  assign ack[2] = iso_hist[2][0];

  cdc_clear_phase_responder #(.CLEAR_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n[0]), .phase_i(ph_in[0]), .phase_valid_i(valid[0]),
    .phase_ready_o(ready[0]), .isolate_o(iso[0]), .isolate_ack_i(ack[0]),
    .clear_o(clr[0]), .phase_o(ph_out[0]), .err_o(err[0])
  );

  cdc_clear_phase_responder #(.CLEAR_CYCLES(10)) u_dut10 (
    .clk_i(clk), .rst_ni(rst_n[1]), .phase_i(ph_in[1]), .phase_valid_i(valid[1]),
    .phase_ready_o(ready[1]), .isolate_o(iso[1]), .isolate_ack_i(ack[1]),
    .clear_o(clr[1]), .phase_o(ph_out[1]), .err_o(err[1])
  );

  cdc_clear_phase_responder #(.CLEAR_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n[2]), .phase_i(ph_in[2]), .phase_valid_i(valid[2]),
    .phase_ready_o(ready[2]), .isolate_o(iso[2]), .isolate_ack_i(ack[2]),
    .clear_o(clr[2]), .phase_o(ph_out[2]), .err_o(err[2])
  );

  task automatic do_reset(input int u);
    rst_n[u] = 1'b0;
    valid[u] = 1'b0;
    ph_in[u] = PhaseIdle;
    repeat (2) @(negedge clk);
    rst_n[u] = 1'b1;
    @(negedge clk);
  endtask

  // Presents one request and measures it; lat is the cycle index (c1 = 1) of ready, -1 on timeout.
  task automatic send_req(input int u, input clear_seq_phase_e p, input int ack_rise,
                          output int lat, output int err_c1, output int err_late,
                          output int clr_pre, output int bad_inv);
    lat = -1; err_c1 = 0; err_late = 0; clr_pre = 0; bad_inv = 0;
    @(negedge clk);
    valid[u] = 1'b1;
    ph_in[u] = p;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (ack_rise > 0 && k == ack_rise) ack_man = 1'b1;
      if (err[u]) begin
        if (k == 1) err_c1 = 1;
        else        err_late++;
      end
      if (clr[u] && !iso[u]) bad_inv++;
      if (ready[u]) begin
        lat = k;
        break;
      end
      if (clr[u]) clr_pre++;
    end
    @(posedge clk);
    #1;
    valid[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < NU; u++) begin
      n_checks++;
      if ({ready[u], iso[u], clr[u], err[u], ph_out[u]} !== {4'b0000, PhaseIdle}) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: got rdy/iso/clr/err=%b%b%b%b phase=%0d, expected 0000 phase=0",
                 u, ready[u], iso[u], clr[u], err[u], ph_out[u]);
      end
    end
  endtask

  task automatic test_full_sequence();
    int lat, e1, el, cp, bi, errs, inv;
    errs = 0; inv = 0;
    do_reset(0);
    send_req(0, PhaseIsolate, 0, lat, e1, el, cp, bi);
    errs += e1 + el; inv += bi;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL full_isolate_latency: got %0d expected 3", lat); end
    send_req(0, PhaseClear, 0, lat, e1, el, cp, bi);
    errs += e1 + el; inv += bi;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL full_clear_latency: got %0d expected 4", lat); end
    n_checks++; if (cp !== 3) begin n_fail++; $display("FAIL full_clear_hold: got %0d cycles expected 3", cp); end
    n_checks++; if (clr[0] !== 1'b1) begin n_fail++; $display("FAIL full_clear_held: got %b expected 1", clr[0]); end
    send_req(0, PhasePostClear, 0, lat, e1, el, cp, bi);
    errs += e1 + el; inv += bi;
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL full_post_clear_latency: got %0d expected 1", lat); end
    n_checks++; if (clr[0] !== 1'b0) begin n_fail++; $display("FAIL full_clear_dropped: got %b expected 0", clr[0]); end
    send_req(0, PhaseIdle, 0, lat, e1, el, cp, bi);
    errs += e1 + el; inv += bi;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL full_idle_latency: got %0d expected 3", lat); end
    n_checks++; if (ph_out[0] !== PhaseIdle) begin n_fail++; $display("FAIL full_final_phase: got %0d expected 0", ph_out[0]); end
    n_checks++; if (iso[0] !== 1'b0) begin n_fail++; $display("FAIL full_final_isolate: got %b expected 0", iso[0]); end
    n_checks++; if (errs !== 0) begin n_fail++; $display("FAIL full_no_err: got %0d pulses expected 0", errs); end
    n_checks++; if (inv !== 0) begin n_fail++; $display("FAIL full_clear_without_isolate: got %0d expected 0", inv); end
  endtask

  task automatic test_illegal();
    int lat, e1, el, cp, bi;
    do_reset(0);
    send_req(0, PhaseClear, 0, lat, e1, el, cp, bi);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL illegal_latency: got %0d expected 1", lat); end
    n_checks++; if (e1 !== 1) begin n_fail++; $display("FAIL illegal_err_c1: got %0d expected 1", e1); end
    n_checks++; if ({clr[0], iso[0]} !== 2'b00) begin n_fail++; $display("FAIL illegal_outputs: got clr/iso=%b%b expected 00", clr[0], iso[0]); end
    n_checks++; if (ph_out[0] !== PhaseIdle) begin n_fail++; $display("FAIL illegal_phase: got %0d expected 0", ph_out[0]); end
    n_checks++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL illegal_err_one_cycle: got %b expected 0", err[0]); end
  endtask

  task automatic test_repeat();
    int lat, e1, el, cp, bi;
    do_reset(0);
    send_req(0, PhaseIsolate, 0, lat, e1, el, cp, bi);
    send_req(0, PhaseIsolate, 0, lat, e1, el, cp, bi);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL repeat_latency: got %0d expected 1", lat); end
    n_checks++; if (e1 + el !== 0) begin n_fail++; $display("FAIL repeat_no_err: got %0d expected 0", e1 + el); end
    n_checks++; if ({iso[0], clr[0], ph_out[0]} !== {2'b10, PhaseIsolate}) begin
      n_fail++; $display("FAIL repeat_outputs: got iso/clr=%b%b phase=%0d expected 10 phase=1", iso[0], clr[0], ph_out[0]);
    end
  endtask

  task automatic test_stalled_ack();
    int lat, e1, el, cp, bi;
    do_reset(0);
    ack_man = 1'b0;
    ack_manual = 1'b1;
    send_req(0, PhaseIsolate, 51, lat, e1, el, cp, bi);
    n_checks++; if (lat !== 52) begin n_fail++; $display("FAIL stalled_ack_latency: got %0d expected 52", lat); end
    n_checks++; if (iso[0] !== 1'b1) begin n_fail++; $display("FAIL stalled_ack_isolate: got %b expected 1", iso[0]); end
    ack_manual = 1'b0;
    ack_man = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int lat, e1, el, cp, bi, hi;
    hi = 0;
    do_reset(1);
    send_req(1, PhaseIsolate, 0, lat, e1, el, cp, bi);
    @(negedge clk);
    valid[1] = 1'b1;
    ph_in[1] = PhaseClear;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (clr[1]) hi++;
    end
    rst_n[1] = 1'b0;
    #1;
    n_checks++; if (hi !== 5) begin n_fail++; $display("FAIL midrst_clear_before: got %0d cycles expected 5", hi); end
    n_checks++; if ({clr[1], iso[1], ready[1]} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_async_drop: got clr/iso/rdy=%b%b%b expected 000", clr[1], iso[1], ready[1]);
    end
    valid[1] = 1'b0;
    ph_in[1] = PhaseIdle;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    n_checks++; if (ph_out[1] !== PhaseIdle) begin n_fail++; $display("FAIL midrst_phase: got %0d expected 0", ph_out[1]); end
    send_req(1, PhaseIsolate, 0, lat, e1, el, cp, bi);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midrst_fresh_isolate: got %0d expected 3", lat); end
    n_checks++; if ({iso[1], ph_out[1]} !== {1'b1, PhaseIsolate}) begin
      n_fail++; $display("FAIL midrst_fresh_state: got iso=%b phase=%0d expected iso=1 phase=1", iso[1], ph_out[1]);
    end
  endtask

  task automatic test_clear_one();
    int lat, e1, el, cp, bi;
    do_reset(2);
    send_req(2, PhaseIsolate, 0, lat, e1, el, cp, bi);
    send_req(2, PhaseClear, 0, lat, e1, el, cp, bi);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL clear1_latency: got %0d expected 2", lat); end
    n_checks++; if (cp !== 1) begin n_fail++; $display("FAIL clear1_rise_c1: got %0d cycles expected 1", cp); end
  endtask

  task automatic test_random();
    clear_seq_phase_e model, p;
    int lat, e1, el, cp, bi, exp_lat, exp_err, r;
    logic [1:0] v;
    do_reset(0);
    model = PhaseIdle;
    for (int it = 0; it < 80; it++) begin
      if (model == PhaseIdle && $urandom_range(3) == 0) begin
        repeat (10) @(negedge clk);
        ack_dly = 3'($urandom_range(1, 4));
      end
      r = int'($urandom_range(9));
      if (r < 6)      v = 2'(int'(model) + 1);
      else if (r < 8) v = model;
      else            v = 2'($urandom_range(3));
      p = clear_seq_phase_e'(v);

      exp_err = 0;
      if (p == model) begin
        exp_lat = 1;
      end else if (int'(p) == (int'(model) + 1) % 4) begin
        case (p)
          PhaseIsolate, PhaseIdle: exp_lat = 2 + int'(ack_dly);
          PhaseClear:              exp_lat = 3 + 1;
          default:                 exp_lat = 1;
        endcase
        model = p;
      end else begin
        exp_lat = 1;
        exp_err = 1;
      end

      send_req(0, p, 0, lat, e1, el, cp, bi);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_latency[%0d]: req=%0d got %0d expected %0d", it, p, lat, exp_lat); end
      n_checks++; if (e1 !== exp_err) begin n_fail++; $display("FAIL rand_err[%0d]: req=%0d got %0d expected %0d", it, p, e1, exp_err); end
      n_checks++; if (el + bi !== 0) begin n_fail++; $display("FAIL rand_stray_events[%0d]: got %0d expected 0", it, el + bi); end
      n_checks++;
      if ({ph_out[0], iso[0], clr[0]} !== {model, model != PhaseIdle, model == PhaseClear}) begin
        n_fail++;
        $display("FAIL rand_state[%0d]: got phase=%0d iso=%b clr=%b expected phase=%0d iso=%b clr=%b",
                 it, ph_out[0], iso[0], clr[0], model, model != PhaseIdle, model == PhaseClear);
      end
    end
    ack_dly = 3'd1;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_n[u] = 1'b0;
      valid[u] = 1'b0;
      ph_in[u] = PhaseIdle;
    end
    ack_manual = 1'b0;
    ack_man    = 1'b0;
    ack_dly    = 3'd1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < NU; u++) rst_n[u] = 1'b1;
    @(negedge clk);

    test_reset();
    test_full_sequence();
    test_illegal();
    test_repeat();
    test_stalled_ack();
    test_reset_mid_clear();
    test_clear_one();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
